// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : switch_pkg
// Brief   : Frame delimiters and FSM/error encodings shared by the receiver.
// Rev     : 1.0 - initial release
// ============================================================================
package switch_pkg;

    localparam logic [7:0] SOF_BYTE = 8'h55;
    localparam logic [7:0] EOF_BYTE = 8'hAA;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_DA        = 3'd1,
        RX_SA        = 3'd2,
        RX_LEN       = 3'd3,
        RX_PAYLOAD   = 3'd4,
        RX_PARITY    = 3'd5,
        RX_EOF       = 3'd6,
        RX_ERR_FLUSH = 3'd7
    } rx_state_e;

    typedef enum logic [1:0] {
        ERR_OK         = 2'd0,
        ERR_BAD_LEN    = 2'd1,
        ERR_BAD_PARITY = 2'd2,
        ERR_BAD_EOF    = 2'd3
    } rx_err_e;

endpackage
`default_nettype wire

// File: rtl/switch_frame_receiver_if.sv
`default_nettype none
// ============================================================================
// Module  : switch_frame_receiver_if
// Brief   : Byte input and parsed-frame outputs of the switch frame receiver.
// Rev     : 1.0 - initial release
// ============================================================================
interface switch_frame_receiver_if;

    logic [7:0] data_in;
    logic       sw_enable_in;
    logic       read_out;
    logic [7:0] da_out;
    logic [7:0] sa_out;
    logic [7:0] length_out;
    logic [7:0] payload_data;
    logic       payload_valid;
    logic       payload_last;
    logic       frame_done;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output data_in, sw_enable_in,
        input  read_out, da_out, sa_out, length_out, payload_data,
               payload_valid, payload_last, frame_done, err_code, busy
    );

    modport slave (
        input  data_in, sw_enable_in,
        output read_out, da_out, sa_out, length_out, payload_data,
               payload_valid, payload_last, frame_done, err_code, busy
    );

endinterface
`default_nettype wire

// File: rtl/switch_rx_parity_acc.sv
`default_nettype none
// ============================================================================
// Module  : switch_rx_parity_acc
// Brief   : Running 8-bit XOR of accepted header/payload bytes.
// Rev     : 1.0 - initial release
// ============================================================================
module switch_rx_parity_acc (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic [7:0] byte_i,
    output logic [7:0] acc_o
);

    logic [7:0] acc_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= 8'h00;
        end else if (clear_i) begin
            acc_q <= 8'h00;
        end else if (enable_i) begin
            acc_q <= acc_q ^ byte_i;
        end
    end

    assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/switch_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module  : switch_frame_receiver
// Brief   : SOF/DA/SA/LEN/PAYLOAD/PARITY/EOF frame parser with registered
//           outputs. Parity checking is built only with SWITCH_RX_PARITY_CHECK_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module switch_frame_receiver
    import switch_pkg::*;
#(
    parameter int MAX_LEN = 255
) (
    input  logic                  clock,
    input  logic                  reset_n,
    switch_frame_receiver_if.slave bus
);

    localparam logic [2:0] S_IDLE      = 3'(RX_IDLE);
    localparam logic [2:0] S_DA        = 3'(RX_DA);
    localparam logic [2:0] S_SA        = 3'(RX_SA);
    localparam logic [2:0] S_LEN       = 3'(RX_LEN);
    localparam logic [2:0] S_PAYLOAD   = 3'(RX_PAYLOAD);
    localparam logic [2:0] S_PARITY    = 3'(RX_PARITY);
    localparam logic [2:0] S_EOF       = 3'(RX_EOF);
    localparam logic [2:0] S_ERR_FLUSH = 3'(RX_ERR_FLUSH);
    // One bit wider than LENGTH so MAX_LEN = 255 still compares meaningfully.
    localparam logic [8:0] C_MAX_LEN   = 9'(MAX_LEN);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] da_q, da_d;
    logic [7:0] sa_q, sa_d;
    logic [7:0] len_q, len_d;
    logic [7:0] pdata_q, pdata_d;
    logic       pvalid_q, pvalid_d;
    logic       plast_q, plast_d;
    logic       done_q, done_d;
    logic       read_q, read_d;
    logic [1:0] err_q, err_d;
    logic       perr_q, perr_d;
    logic       busy_q;

    logic [7:0] w_byte;
    logic       w_en;
    logic       w_par_mismatch;

    assign w_byte = bus.data_in;
    assign w_en   = bus.sw_enable_in;

`ifdef SWITCH_RX_PARITY_CHECK_EN
    logic       w_acc_clear;
    logic       w_acc_en;
    logic [7:0] w_acc;

    assign w_acc_clear = w_en && (state_q == S_IDLE) && (w_byte == SOF_BYTE);
    assign w_acc_en    = w_en && ((state_q == S_DA) || (state_q == S_SA) ||
                                  (state_q == S_LEN) || (state_q == S_PAYLOAD));

    if (1) begin : g_parity_acc
        switch_rx_parity_acc u_acc (
            .clock    (clock),
            .reset_n  (reset_n),
            .clear_i  (w_acc_clear),
            .enable_i (w_acc_en),
            .byte_i   (w_byte),
            .acc_o    (w_acc)
        );
    end

    assign w_par_mismatch = (w_byte != w_acc);
`else
    assign w_par_mismatch = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        da_d     = da_q;
        sa_d     = sa_q;
        len_d    = len_q;
        pdata_d  = pdata_q;
        perr_d   = perr_q;
        pvalid_d = 1'b0;
        plast_d  = 1'b0;
        done_d   = 1'b0;
        read_d   = 1'b0;
        err_d    = ERR_OK;
        if (w_en) begin
            case (state_q)
                S_IDLE: begin
                    if (w_byte == SOF_BYTE) begin
                        state_d = S_DA;
                        perr_d  = 1'b0;
                    end
                end
                S_DA: begin
                    da_d    = w_byte;
                    state_d = S_SA;
                end
                S_SA: begin
                    sa_d    = w_byte;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    len_d = w_byte;
                    cnt_d = w_byte;
                    if (w_byte == 8'd0) begin
                        state_d = S_PARITY;
                    end else if ({1'b0, w_byte} > C_MAX_LEN) begin
                        state_d = S_ERR_FLUSH;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    pvalid_d = 1'b1;
                    pdata_d  = w_byte;
                    plast_d  = (cnt_q == 8'd1);
                    cnt_d    = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    perr_d  = w_par_mismatch;
                    state_d = S_EOF;
                end
                S_EOF: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    // A bad terminator outranks a latched parity mismatch.
                    if (w_byte != EOF_BYTE) begin
                        err_d = ERR_BAD_EOF;
                    end else if (perr_q) begin
                        err_d = ERR_BAD_PARITY;
                    end else begin
                        read_d = 1'b1;
                    end
                end
                S_ERR_FLUSH: begin
                    if (w_byte == EOF_BYTE) begin
                        done_d  = 1'b1;
                        err_d   = ERR_BAD_LEN;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'h00;
            da_q     <= 8'h00;
            sa_q     <= 8'h00;
            len_q    <= 8'h00;
            pdata_q  <= 8'h00;
            pvalid_q <= 1'b0;
            plast_q  <= 1'b0;
            done_q   <= 1'b0;
            read_q   <= 1'b0;
            err_q    <= 2'd0;
            perr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            da_q     <= da_d;
            sa_q     <= sa_d;
            len_q    <= len_d;
            pdata_q  <= pdata_d;
            pvalid_q <= pvalid_d;
            plast_q  <= plast_d;
            done_q   <= done_d;
            read_q   <= read_d;
            err_q    <= err_d;
            perr_q   <= perr_d;
            busy_q   <= (state_d != S_IDLE);
        end
    end

    assign bus.read_out      = read_q;
    assign bus.da_out        = da_q;
    assign bus.sa_out        = sa_q;
    assign bus.length_out    = len_q;
    assign bus.payload_data  = pdata_q;
    assign bus.payload_valid = pvalid_q;
    assign bus.payload_last  = plast_q;
    assign bus.frame_done    = done_q;
    assign bus.err_code      = err_q;
    assign bus.busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module  : tb_switch_frame_receiver
// Brief   : Self-checking bench: frame table, corner sequences, random frames.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_switch_frame_receiver;
    import switch_pkg::*;

    localparam int TB_MAX_LEN = 16;
`ifdef SWITCH_RX_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam logic [1:0] P_ERR = PAR_EN ? 2'd2 : 2'd0;
    localparam logic       P_RD  = PAR_EN ? 1'b0 : 1'b1;

    typedef struct packed {
        logic [1:0] err;
        logic       rd;
        logic [7:0] da;
        logic [7:0] sa;
        logic [7:0] len;
    } done_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    typedef struct {
        logic [7:0] da, sa, len, pbase, flip, eof;
        logic [1:0] exp_err;
        logic       exp_rd;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    switch_frame_receiver_if bus();

    switch_frame_receiver #(.MAX_LEN(TB_MAX_LEN)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    beat_t      got_beats[$], exp_beats[$];
    done_t      got_done[$], exp_done[$];
    int         read_times[$];
    logic [7:0] frame[$];
    int         cyc = 0;
    int         stray = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.payload_valid) got_beats.push_back({bus.payload_last, bus.payload_data});
            if (bus.frame_done)
                got_done.push_back({bus.err_code, bus.read_out, bus.da_out, bus.sa_out, bus.length_out});
            if (bus.read_out) read_times.push_back(cyc);
            if ((bus.payload_last && !bus.payload_valid) ||
                (!bus.frame_done && (bus.err_code != 2'd0 || bus.read_out))) stray++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: slice the accepted byte stream into frame fields directly.
    task automatic model(input logic [7:0] fb[$]);
        int         i = 0;
        int         n;
        logic [7:0] par;
        done_t      d;
        while (i < fb.size() && fb[i] != SOF_BYTE) i++;
        if (i + 3 >= fb.size()) return;
        d.da  = fb[i+1];
        d.sa  = fb[i+2];
        d.len = fb[i+3];
        d.rd  = 1'b0;
        n     = int'(d.len);
        if (n > TB_MAX_LEN) begin
            d.err = 2'd1;
            for (int j = i + 4; j < fb.size(); j++) begin
                if (fb[j] == EOF_BYTE) begin
                    exp_done.push_back(d);
                    return;
                end
            end
            return;
        end
        if (i + 5 + n >= fb.size()) return;
        par = d.da ^ d.sa ^ d.len;
        for (int k = 0; k < n; k++) begin
            par ^= fb[i+4+k];
            exp_beats.push_back({(k == n - 1), fb[i+4+k]});
        end
        if (fb[i+5+n] != EOF_BYTE)            d.err = 2'd3;
        else if (PAR_EN && fb[i+4+n] != par)  d.err = 2'd2;
        else                                  d.err = 2'd0;
        d.rd = (d.err == 2'd0);
        exp_done.push_back(d);
    endtask

    task automatic compare_frame(input string tag);
        check({tag, " beats"}, 32'(got_beats.size()), 32'(exp_beats.size()));
        for (int k = 0; k < got_beats.size() && k < exp_beats.size(); k++)
            check({tag, " beat"}, 32'(got_beats[k]), 32'(exp_beats[k]));
        check({tag, " frames"}, 32'(got_done.size()), 32'(exp_done.size()));
        for (int k = 0; k < got_done.size() && k < exp_done.size(); k++)
            check({tag, " done fields"}, 32'(got_done[k]), 32'(exp_done[k]));
        check({tag, " stray pulses"}, 32'(stray), 32'd0);
        got_beats.delete(); exp_beats.delete();
        got_done.delete();  exp_done.delete();
        read_times.delete();
        stray = 0;
    endtask

    task automatic drive(input logic en, input logic [7:0] d);
        bus.sw_enable_in = en;
        bus.data_in      = d;
        @(negedge clock);
    endtask

    task automatic drive_bytes(input logic [7:0] fb[$], input int stall_pct);
        foreach (fb[k]) begin
            for (int s = 0; s < 3 && $urandom_range(0, 99) < stall_pct; s++)
                drive(1'b0, 8'($urandom));
            drive(1'b1, fb[k]);
        end
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
    endtask

    task automatic build_frame(input logic [7:0] da, sa, len, pbase, flip, eof, input int npay);
        logic [7:0] par;
        frame.delete();
        par = da ^ sa ^ len;
        frame.push_back(SOF_BYTE);
        frame.push_back(da);
        frame.push_back(sa);
        frame.push_back(len);
        for (int k = 0; k < npay; k++) begin
            frame.push_back(pbase + 8'(k));
            par ^= pbase + 8'(k);
        end
        frame.push_back(par ^ flip);
        frame.push_back(eof);
    endtask

    function automatic logic [7:0] rand_not(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] v;
        v = 8'($urandom);
        while (v == a || v == b) v = 8'($urandom);
        return v;
    endfunction

    vec_t       tbl[11];
    logic [7:0] f1[$];

    initial begin
        tbl[0]  = '{8'h01, 8'h02, 8'd3,  8'hA0, 8'h00, 8'hAA, 2'd0, 1'b1};
        tbl[1]  = '{8'h11, 8'h22, 8'd0,  8'h30, 8'h00, 8'hAA, 2'd0, 1'b1};
        tbl[2]  = '{8'h33, 8'h44, 8'd1,  8'h30, 8'h00, 8'hAA, 2'd0, 1'b1};
        tbl[3]  = '{8'h5A, 8'hA5, 8'd16, 8'h30, 8'h00, 8'hAA, 2'd0, 1'b1};
        tbl[4]  = '{8'h5A, 8'hA5, 8'd17, 8'h30, 8'h00, 8'hAA, 2'd1, 1'b0};
        tbl[5]  = '{8'h01, 8'h02, 8'd3,  8'hA0, 8'h01, 8'hAA, P_ERR, P_RD};
        tbl[6]  = '{8'h01, 8'h02, 8'd3,  8'hA0, 8'h00, 8'h00, 2'd3, 1'b0};
        tbl[7]  = '{8'h01, 8'h02, 8'd3,  8'hA0, 8'h01, 8'h00, 2'd3, 1'b0};
        tbl[8]  = '{8'h66, 8'h77, 8'd2,  8'h30, 8'h00, 8'h55, 2'd3, 1'b0};
        tbl[9]  = '{8'h55, 8'hAA, 8'd8,  8'h50, 8'h00, 8'hAA, 2'd0, 1'b1};
        tbl[10] = '{8'h12, 8'h34, 8'd4,  8'hA8, 8'h00, 8'hAA, 2'd0, 1'b1};

        reset_n          = 1'b0;
        bus.data_in      = 8'h00;
        bus.sw_enable_in = 1'b0;
        repeat (3) drive(1'b1, SOF_BYTE);
        check("reset outputs", 32'({bus.read_out, bus.da_out, bus.sa_out, bus.length_out,
                                    bus.payload_data}), 32'd0);
        check("reset flags", 32'({bus.payload_valid, bus.payload_last, bus.frame_done,
                                  bus.err_code, bus.busy}), 32'd0);
        reset_n = 1'b1;
        drive(1'b0, 8'h00);

        foreach (tbl[t]) begin
            build_frame(tbl[t].da, tbl[t].sa, tbl[t].len, tbl[t].pbase, tbl[t].flip,
                        tbl[t].eof, int'(tbl[t].len));
            drive_bytes(frame, 0);
            check("table err", 32'(got_done.size() > 0 ? got_done[0].err : 2'bxx), 32'(tbl[t].exp_err));
            check("table read", 32'(got_done.size() > 0 ? got_done[0].rd : 1'bx), 32'(tbl[t].exp_rd));
            model(frame);
            compare_frame("table");
        end

        // Three stall cycles ahead of each of the last two payload bytes.
        build_frame(8'h01, 8'h02, 8'd3, 8'hA0, 8'h00, 8'hAA, 3);
        foreach (frame[k]) begin
            if (k == 5 || k == 6) repeat (3) begin
                drive(1'b0, SOF_BYTE);
                check("stall no beat", 32'(bus.payload_valid), 32'd0);
            end
            drive(1'b1, frame[k]);
        end
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        check("stall read", 32'(got_done.size() > 0 ? got_done[0].rd : 1'bx), 32'd1);
        model(frame);
        compare_frame("stall");

        build_frame(8'h11, 8'h22, 8'd2, 8'h30, 8'h00, 8'hAA, 2);
        f1 = frame;
        build_frame(8'h33, 8'h44, 8'd4, 8'h40, 8'h00, 8'hAA, 4);
        drive_bytes({f1, frame}, 0);
        check("b2b reads", 32'(read_times.size()), 32'd2);
        check("b2b spacing", 32'(read_times.size() >= 2 ? read_times[1] - read_times[0] : -1),
              32'(frame.size()));
        model(f1);
        model(frame);
        compare_frame("b2b");

        drive(1'b1, 8'h00); check("junk busy", 32'(bus.busy), 32'd0);
        drive(1'b1, 8'hFF); check("junk busy", 32'(bus.busy), 32'd0);
        drive(1'b1, 8'h12); check("junk busy", 32'(bus.busy), 32'd0);
        build_frame(8'h01, 8'h02, 8'd3, 8'hA0, 8'h00, 8'h00, 3);
        drive_bytes(frame, 0);
        check("bad eof err", 32'(got_done.size() > 0 ? got_done[0].err : 2'bxx), 32'd3);
        model(frame);
        compare_frame("bad eof");

        build_frame(8'h07, 8'h08, 8'd5, 8'h60, 8'h00, 8'hAA, 5);
        for (int k = 0; k < 6; k++) drive(1'b1, frame[k]);
        check("pre-reset busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid reset outputs", 32'({bus.read_out, bus.da_out, bus.sa_out, bus.length_out,
                                        bus.payload_data}), 32'd0);
        check("mid reset flags", 32'({bus.payload_valid, bus.payload_last, bus.frame_done,
                                      bus.err_code, bus.busy}), 32'd0);
        drive(1'b1, 8'hAA);
        drive(1'b1, 8'hAA);
        check("mid reset no frame", 32'(got_done.size()), 32'd0);
        got_beats.delete();
        stray   = 0;
        reset_n = 1'b1;
        build_frame(8'h01, 8'h02, 8'd3, 8'hA0, 8'h00, 8'hAA, 3);
        drive_bytes(frame, 0);
        model(frame);
        compare_frame("after reset");

        for (int r = 0; r < 60; r++) begin
            logic [7:0] da, sa, len, par, b;
            logic       bad;
            da  = 8'($urandom);
            sa  = 8'($urandom);
            len = 8'($urandom_range(0, 20));
            bad = (int'(len) > TB_MAX_LEN);
            repeat ($urandom_range(0, 2)) drive(1'b1, rand_not(SOF_BYTE, SOF_BYTE));
            frame.delete();
            frame.push_back(SOF_BYTE);
            frame.push_back(da);
            frame.push_back(sa);
            frame.push_back(len);
            par = da ^ sa ^ len;
            for (int k = 0; k < int'(len); k++) begin
                b = bad ? rand_not(SOF_BYTE, EOF_BYTE) : 8'($urandom);
                frame.push_back(b);
                par ^= b;
            end
            if (bad) frame.push_back(rand_not(SOF_BYTE, EOF_BYTE));
            else if ($urandom_range(0, 3) == 0) frame.push_back(par ^ 8'($urandom_range(1, 255)));
            else frame.push_back(par);
            if (!bad && $urandom_range(0, 4) == 0) frame.push_back(rand_not(EOF_BYTE, EOF_BYTE));
            else frame.push_back(EOF_BYTE);
            drive_bytes(frame, 25);
            model(frame);
            compare_frame("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_frame_receiver.md
# switch_frame_receiver

Input-side frame parser of the switch: consumes the byte stream presented on `data_in` qualified by `sw_enable_in`, walks the SOF/DA/SA/LENGTH/PAYLOAD/PARITY/EOF frame format, and emits the header fields and a registered payload byte stream. It also reports frame completion and status, and drives `read_out` to acknowledge each good frame. It sits directly behind the control port, at the other end of the interface that the bench's control driver feeds.

## Interface
- MAX_LEN, 255: largest LENGTH value accepted; frames with LENGTH > MAX_LEN are rejected.
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- data_in  in  8  frame byte.
- sw_enable_in  in  1  byte qualifier; `data_in` is consumed only in cycles where this is 1.
- read_out  out  1  one-cycle pulse: a frame completed with no error.
- da_out  out  8  captured DA; held until the next frame's DA.
- sa_out  out  8  captured SA; held until the next frame's SA.
- length_out  out  8  captured LENGTH; held until the next frame's LENGTH.
- payload_data  out  8  payload byte.
- payload_valid  out  1  `payload_data` is valid this cycle.
- payload_last  out  1  with `payload_valid`: final payload byte.
- frame_done  out  1  one-cycle pulse at the end of any frame, good or bad.
- err_code  out  2  valid with `frame_done`: 0 OK, 1 BAD_LEN, 2 BAD_PARITY, 3 BAD_EOF.
- busy  out  1  FSM is not in IDLE.

## Operation
- FSM states and transitions:
  - IDLE: SOF_BYTE → DA; any other byte is discarded and the FSM stays in IDLE.
  - DA → SA, capturing `da_out`.
  - SA → LEN, capturing `sa_out`.
  - LEN: captures `length_out` and loads the remaining-byte counter with LENGTH.
    - LENGTH = 0 → PARITY.
    - LENGTH > MAX_LEN → ERR_FLUSH with err_code 1.
    - Otherwise → PAYLOAD.
  - PAYLOAD: each accepted byte decrements the counter; the byte at counter = 1 → PARITY.
  - PARITY: compares the byte with the accumulator → EOF.
  - EOF: EOF_BYTE → IDLE with `frame_done`; any other byte → IDLE with err_code 3.
  - ERR_FLUSH: discards bytes until EOF_BYTE, then pulses `frame_done` with err_code 1 and returns to IDLE.
- Stall: a cycle with `sw_enable_in` = 0 holds all state; no transition and no output pulse.
- Parity: XOR of DA, SA, LENGTH and every payload byte, 8 bits wide, cleared when SOF is accepted.
- Error priority within one frame:
  - BAD_EOF overrides BAD_PARITY.
  - A parity mismatch is latched and reported at EOF.
- `read_out` pulses only when err_code = 0.
- Back-to-back frames: SOF in the cycle immediately after EOF is accepted; no idle cycle is required.
- Reset mid-frame: the FSM returns to IDLE and the partial frame produces no `frame_done`.
- Reset values:
  - All outputs are 0.
  - Counter and accumulator are 0.
  - State is IDLE.

## Timing
- All outputs are registered.
- `payload_valid`/`payload_data` assert in the cycle after the byte is sampled.
- `da_out`/`sa_out`/`length_out` update in the cycle after their byte is sampled.
- `frame_done`, `err_code` and `read_out` assert for exactly one cycle, the cycle after EOF (or the terminating byte) is sampled.
- Minimum frame: 6 accepted bytes (LENGTH = 0).
- Throughput: one byte per cycle, with no back-pressure.

## Configuration
- SWITCH_RX_PARITY_CHECK_EN defined: parity is compared and a mismatch yields err_code 2.
- Macro undefined:
  - The PARITY byte is still consumed.
  - The accumulator and comparator are not instantiated.
  - err_code 2 is never produced.

## Structure
- Shared package `switch_pkg` holds:
  - SOF_BYTE = 8'h55 and EOF_BYTE = 8'hAA.
  - The `rx_state_e` FSM enum.
  - The `rx_err_e` error enum (2 bits).
- Sub-module `switch_rx_parity_acc` holds:
  - Inputs: clear, enable and byte.
  - Output: the running 8-bit XOR.
  - It is instantiated only under SWITCH_RX_PARITY_CHECK_EN.

## Test plan
- Good frame:
  - Stimulus: 55,01,02,03,A0,A1,A2,parity=A0^A1^A2^01^02^03,AA with `sw_enable_in` = 1 throughout.
  - Response: 3 `payload_valid` beats, with `payload_last` on A2.
  - Response: `read_out` = `frame_done` = 1 for one cycle, err_code 0, da_out = 01, sa_out = 02.
- Stalls: the same frame with `sw_enable_in` = 0 for 3 cycles between payload bytes gives an identical result, and no beats occur during the stall.
- Back-to-back:
  - Stimulus: two frames with the second SOF sent in the cycle after the first EOF.
  - Response: two `read_out` pulses, spaced exactly the second frame's byte count apart.
- Bad parity:
  - Stimulus: the parity byte XOR'd with 01.
  - Response with the macro defined: err_code 2 and `read_out` = 0.
  - Response with the macro undefined: err_code 0 and `read_out` = 1.
- Bad EOF and junk:
  - Stimulus: 3 junk bytes (00,FF,12) in IDLE are ignored (`busy` stays 0), followed by a frame whose last byte is 00.
  - Response: err_code 3 and no `read_out`.
- Reset mid-payload:
  - Stimulus: deassert `reset_n` after 2 payload bytes.
  - Response: all outputs are 0 immediately and `busy` = 0; a following good frame is received correctly.
